// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I control unit: opcodes, states, mux encodings.
package rv_ctrl_pkg;

  localparam int unsigned MEM_TO_W_DEFAULT = 4;
  localparam int unsigned ALUOP_W_DEFAULT  = 2;
  localparam logic [31:0] RESET_PC         = 32'h0000_0000;

  localparam logic [4:0] OPCODE_BRANCH  = 5'b11000;
  localparam logic [4:0] OPCODE_LOAD    = 5'b00000;
  localparam logic [4:0] OPCODE_STORE   = 5'b01000;
  localparam logic [4:0] OPCODE_JALR    = 5'b11001;
  localparam logic [4:0] OPCODE_JAL     = 5'b11011;
  localparam logic [4:0] OPCODE_ARITH_I = 5'b00100;
  localparam logic [4:0] OPCODE_ARITH_R = 5'b01100;
  localparam logic [4:0] OPCODE_AUIPC   = 5'b00101;
  localparam logic [4:0] OPCODE_LUI     = 5'b01101;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_EXEC_ALU  = 4'd2,
    ST_EXEC_ADDR = 4'd3,
    ST_MEM_LD    = 4'd4,
    ST_MEM_ST    = 4'd5,
    ST_EXEC_BR   = 4'd6,
    ST_JUMP      = 4'd7,
    ST_JUMP_R    = 4'd8,
    ST_UPPER     = 4'd9,
    ST_WB_ALU    = 4'd10,
    ST_WB_LD     = 4'd11,
    ST_TRAP      = 4'd12,
    ST_MULDIV    = 4'd13
  } state_e;

  localparam logic [1:0] PC_SRC_PC4    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JALR   = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC4    = 2'b10;
  localparam logic [1:0] WB_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_RS1  = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_MOP     = 2'b11;

  typedef struct packed {
    logic arith_r;
    logic arith_i;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
  } iclass_t;

endpackage

// File: rtl/rv_opcode_class.sv
// Combinational opcode classifier: one-hot instruction class, illegal flag and M-extension flag.
module rv_opcode_class
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [6:0] funct7_i,
  output iclass_t    cls_o,
  output logic       illegal_o,
  output logic       mop_o
);

  // Only 32-bit encodings (low bits 11) map to a class.
  always_comb begin
    cls_o = '0;
    if (opcode_i[1:0] == 2'b11) begin
      case (opcode_i[6:2])
        OPCODE_ARITH_R: cls_o.arith_r = 1'b1;
        OPCODE_ARITH_I: cls_o.arith_i = 1'b1;
        OPCODE_LOAD:    cls_o.load    = 1'b1;
        OPCODE_STORE:   cls_o.store   = 1'b1;
        OPCODE_BRANCH:  cls_o.branch  = 1'b1;
        OPCODE_JAL:     cls_o.jal     = 1'b1;
        OPCODE_JALR:    cls_o.jalr    = 1'b1;
        OPCODE_LUI:     cls_o.lui     = 1'b1;
        OPCODE_AUIPC:   cls_o.auipc   = 1'b1;
        default:        ;
      endcase
    end
  end

  assign illegal_o = (cls_o == '0);
  assign mop_o     = cls_o.arith_r && (funct7_i == 7'b0000001);

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM with bounded memory waits and trap handling.
// Define RV_CTRL_MULDIV_EN to add the MULDIV state and md_start/md_done handshake.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TO_W = MEM_TO_W_DEFAULT,
  parameter int unsigned ALUOP_W  = ALUOP_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic               mem_ready,
  input  logic               br_taken,
  input  logic               trap_ack,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               addr_sel,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_write,
  output logic [1:0]         wb_sel,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [3:0]         state_o
`ifdef RV_CTRL_MULDIV_EN
  ,
  output logic               md_start,
  input  logic               md_done
`endif
);

  state_e              state_q, state_d;
  logic [MEM_TO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]          cause_q, cause_d;
  iclass_t             cls;
  logic                illegal, mop, waiting, ready_c, tmo;
  logic                unused_instr;

  assign unused_instr = ^instr[24:7];

  rv_opcode_class u_class (
    .opcode_i  (instr[6:0]),
    .funct7_i  (instr[31:25]),
    .cls_o     (cls),
    .illegal_o (illegal),
    .mop_o     (mop)
  );

`ifdef RV_CTRL_MULDIV_EN
  logic md_first_q;
  assign ready_c = (state_q == ST_MULDIV) ? md_done : mem_ready;
  assign waiting = state_q inside {ST_FETCH, ST_MEM_LD, ST_MEM_ST, ST_MULDIV};
`else
  assign ready_c = mem_ready;
  assign waiting = state_q inside {ST_FETCH, ST_MEM_LD, ST_MEM_ST};
`endif

  // Timeout fires on the waiting cycle that would bring the counter to all-ones.
  assign cnt_inc = cnt_q + MEM_TO_W'(1);
  assign tmo     = waiting && !ready_c && (cnt_inc == {MEM_TO_W{1'b1}});

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_FETCH: if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (illegal) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
`ifndef RV_CTRL_MULDIV_EN
        else if (mop) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_MOP;
        end
`endif
        else if (cls.arith_r || cls.arith_i) state_d = ST_EXEC_ALU;
        else if (cls.load || cls.store)      state_d = ST_EXEC_ADDR;
        else if (cls.branch)                 state_d = ST_EXEC_BR;
        else if (cls.jal)                    state_d = ST_JUMP;
        else if (cls.jalr)                   state_d = ST_JUMP_R;
        else                                 state_d = ST_UPPER;
      end
`ifdef RV_CTRL_MULDIV_EN
      ST_EXEC_ALU:  state_d = mop ? ST_MULDIV : ST_WB_ALU;
      ST_MULDIV:    if (md_done) state_d = ST_WB_ALU;
`else
      ST_EXEC_ALU:  state_d = ST_WB_ALU;
`endif
      ST_EXEC_ADDR: state_d = cls.load ? ST_MEM_LD : ST_MEM_ST;
      ST_MEM_LD:    if (mem_ready) state_d = ST_WB_LD;
      ST_MEM_ST:    if (mem_ready) state_d = ST_FETCH;
      ST_TRAP: begin
        if (trap_ack) begin
          state_d = ST_FETCH;
          cause_d = CAUSE_NONE;
        end
      end
      default:      state_d = ST_FETCH;
    endcase
    if (tmo) begin
      state_d = ST_TRAP;
      cause_d = CAUSE_TIMEOUT;
    end
    if (state_d != state_q)       cnt_d = '0;
    else if (waiting && !ready_c) cnt_d = cnt_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

`ifdef RV_CTRL_MULDIV_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) md_first_q <= 1'b0;
    else     md_first_q <= (state_d == ST_MULDIV) && (state_q != ST_MULDIV);
  end
`endif

  // Datapath strobes; forced low while reset is asserted.
  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_PC4;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr_sel   = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_W'(ALUOP_ADD);
    reg_write  = 1'b0;
    wb_sel     = WB_ALUOUT;
    trap       = 1'b0;
    trap_cause = CAUSE_NONE;
`ifdef RV_CTRL_MULDIV_EN
    md_start   = 1'b0;
`endif
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        ST_DECODE:   alu_src_b = SRCB_IMM;
        ST_EXEC_ALU: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = cls.arith_r ? SRCB_RS2 : SRCB_IMM;
          alu_op    = ALUOP_W'(ALUOP_FUNCT);
        end
        ST_EXEC_ADDR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        ST_MEM_LD: begin
          mem_read = 1'b1;
          addr_sel = 1'b1;
        end
        ST_MEM_ST: begin
          mem_write = 1'b1;
          addr_sel  = 1'b1;
        end
        ST_EXEC_BR: begin
          alu_src_a = SRCA_RS1;
          alu_op    = ALUOP_W'(ALUOP_BR);
          pc_write  = br_taken;
          pc_src    = PC_SRC_ALUOUT;
        end
        ST_JUMP: begin
          reg_write = 1'b1;
          wb_sel    = WB_PC4;
          pc_write  = 1'b1;
          pc_src    = PC_SRC_ALUOUT;
        end
        ST_JUMP_R: begin
          reg_write = 1'b1;
          wb_sel    = WB_PC4;
          pc_write  = 1'b1;
          pc_src    = PC_SRC_JALR;
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        ST_UPPER: begin
          reg_write = 1'b1;
          wb_sel    = cls.lui ? WB_IMM : WB_ALUOUT;
        end
        ST_WB_ALU: reg_write = 1'b1;
        ST_WB_LD: begin
          reg_write = 1'b1;
          wb_sel    = WB_MDR;
        end
        ST_TRAP: begin
          trap       = 1'b1;
          trap_cause = cause_q;
        end
`ifdef RV_CTRL_MULDIV_EN
        ST_MULDIV: md_start = md_first_q;
`endif
        default: ;
      endcase
    end
  end

  assign state_o = state_q;

endmodule
